// File: rtl/glb_pkg.sv
// Shared GLB definitions: default widths, read-agent FSM states and monitor field offsets.
package glb_pkg;
  localparam int GLB_SRAM_WIDTH     = 256;
  localparam int GLB_ADDR_WIDTH     = 16;
  localparam int MON_FIELD_W        = 32;
  localparam int MON_ADDR_STALL_LSB = 0;
  localparam int MON_OUT_STALL_LSB  = 32;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} glb_rd_agent_state_t;
endpackage

// File: rtl/glb_rd_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head word is always on dout.
module glb_rd_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // a full FIFO still takes a word in the same cycle its head leaves
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/glb_rd_agent.sv
// GLB read-port initiator: strided block read with credit-reserved return buffer.
// Optional stall monitor counters on MonDat when GLB_RD_AGENT_MON_EN is defined.
module glb_rd_agent
  import glb_pkg::*;
#(
  parameter int SRAM_WIDTH = GLB_SRAM_WIDTH,
  parameter int ADDR_WIDTH = GLB_ADDR_WIDTH,
  parameter int NUM_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CfgVld,
  output logic                  CfgRdy,
  input  logic [ADDR_WIDTH-1:0] CfgBaseAddr,
  input  logic [ADDR_WIDTH-1:0] CfgStride,
  input  logic [NUM_WIDTH-1:0]  CfgNum,
  output logic [ADDR_WIDTH-1:0] RdAddr,
  output logic                  RdAddrVld,
  input  logic                  RdAddrRdy,
  input  logic [SRAM_WIDTH-1:0] RdDat,
  input  logic                  RdDatVld,
  output logic                  RdDatRdy,
  output logic [SRAM_WIDTH-1:0] OutDat,
  output logic                  OutDatVld,
  input  logic                  OutDatRdy,
  output logic                  OutLast,
  output logic                  Busy,
  output logic                  Done,
  output logic [63:0]           MonDat
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  glb_rd_agent_state_t state, nxt_state;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [NUM_WIDTH-1:0]  num_q, req_cnt, out_cnt;
  logic [CW-1:0]         outstanding, fifo_count;
  logic [SW-1:0]         credit_nxt;
  logic cfg_hs, addr_hs, dat_hs, out_hs, fifo_full, fifo_empty;
  logic last_req, last_out, req_left;

  assign cfg_hs    = CfgVld && CfgRdy;
  assign addr_hs   = RdAddrVld && RdAddrRdy;
  assign dat_hs    = RdDatVld && RdDatRdy;
  assign out_hs    = OutDatVld && OutDatRdy;
  assign RdDatRdy  = !fifo_full;
  assign OutDatVld = !fifo_empty;
  assign last_req  = (req_cnt == num_q - NUM_WIDTH'(1));
  assign last_out  = (out_cnt == num_q - NUM_WIDTH'(1));
  assign OutLast   = OutDatVld && last_out;
  assign req_left  = !(addr_hs && last_req);
  // reserved slots next cycle; the returning word moves from outstanding into the FIFO
  assign credit_nxt = SW'(outstanding) + SW'(fifo_count) + SW'(addr_hs) - SW'(out_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:  if (CfgVld) nxt_state = (CfgNum == '0) ? DONE : REQ;
      REQ:   if (addr_hs && last_req) nxt_state = DRAIN;
      DRAIN: if (out_hs && last_out) nxt_state = DONE;
      DONE:  nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    CfgRdy = (state == IDLE);
    Busy   = (state != IDLE);
    Done   = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q    <= '0;
      num_q       <= '0;
      req_cnt     <= '0;
      out_cnt     <= '0;
      RdAddr      <= '0;
      RdAddrVld   <= 1'b0;
      outstanding <= '0;
    end else begin
      if (cfg_hs) begin
        stride_q  <= CfgStride;
        num_q     <= CfgNum;
        req_cnt   <= '0;
        out_cnt   <= '0;
        RdAddr    <= CfgBaseAddr;
        RdAddrVld <= (CfgNum != '0);
      end else begin
        if (addr_hs) begin
          req_cnt <= req_cnt + NUM_WIDTH'(1);
          RdAddr  <= RdAddr + stride_q;
        end
        if (out_hs) out_cnt <= out_cnt + NUM_WIDTH'(1);
        RdAddrVld <= (state == REQ) && req_left && (credit_nxt < SW'(FIFO_DEPTH));
      end
      outstanding <= outstanding + CW'(addr_hs) - CW'(dat_hs);
    end
  end

  glb_rd_fifo #(.WIDTH(SRAM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst),
    .push(RdDatVld), .din(RdDat),
    .pop(OutDatRdy), .dout(OutDat),
    .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );

  assert property (@(posedge clk) disable iff (rst) !(RdDatVld && !RdDatRdy));

`ifdef GLB_RD_AGENT_MON_EN
  logic [MON_FIELD_W-1:0] addr_stall, out_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_stall <= '0;
      out_stall  <= '0;
    end else if (cfg_hs) begin
      addr_stall <= '0;
      out_stall  <= '0;
    end else begin
      if (RdAddrVld && !RdAddrRdy && (addr_stall != '1)) addr_stall <= addr_stall + MON_FIELD_W'(1);
      if (OutDatVld && !OutDatRdy && (out_stall != '1))  out_stall  <= out_stall + MON_FIELD_W'(1);
    end
  end

  always_comb begin
    MonDat = '0;
    MonDat[MON_ADDR_STALL_LSB +: MON_FIELD_W] = addr_stall;
    MonDat[MON_OUT_STALL_LSB +: MON_FIELD_W]  = out_stall;
  end
`else
  assign MonDat = '0;
`endif
endmodule

// File: tb/tb_glb_rd_agent.sv
// Directed + randomized bench for glb_rd_agent with a GLB latency model and in-order scoreboard.
module tb_glb_rd_agent;
  logic         clk = 1'b0;
  logic         rst;
  logic         CfgVld, CfgRdy;
  logic [15:0]  CfgBaseAddr, CfgStride, CfgNum;
  logic [15:0]  RdAddr;
  logic         RdAddrVld, RdAddrRdy;
  logic [255:0] RdDat;
  logic         RdDatVld, RdDatRdy;
  logic [255:0] OutDat;
  logic         OutDatVld, OutDatRdy, OutLast, Busy, Done;
  logic [63:0]  MonDat;

  glb_rd_agent dut (
    .clk(clk), .rst(rst),
    .CfgVld(CfgVld), .CfgRdy(CfgRdy), .CfgBaseAddr(CfgBaseAddr), .CfgStride(CfgStride), .CfgNum(CfgNum),
    .RdAddr(RdAddr), .RdAddrVld(RdAddrVld), .RdAddrRdy(RdAddrRdy),
    .RdDat(RdDat), .RdDatVld(RdDatVld), .RdDatRdy(RdDatRdy),
    .OutDat(OutDat), .OutDatVld(OutDatVld), .OutDatRdy(OutDatRdy), .OutLast(OutLast),
    .Busy(Busy), .Done(Done), .MonDat(MonDat)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; int due; } glb_req_t;

  int checks = 0, failures = 0, cyc = 0;
  int lat_min = 1, lat_max = 1, out_mode = 0;
  bit addr_rand = 0;

  glb_req_t    glb_q[$];
  int          addr_cyc[$];
  logic [15:0] addr_log[$];
  logic [15:0] cur_base, cur_stride, cur_num;
  int  k_a = 0, k_o = 0, acc_cyc = 0, exp_done = -1, done_cnt = 0, vld_cycles = 0;
  int  a_stall = 0, o_stall = 0;
  bit  hold_a = 0, hold_o = 0, prev_done = 0;
  logic [15:0]  hold_addr;
  logic [255:0] hold_dat;

  function automatic logic [255:0] glb_word(input logic [15:0] a);
    return {{15{a ^ 16'h5A5A}}, a};
  endfunction

  function automatic logic [15:0] exp_addr(input int k);
    return 16'(int'(cur_base) + k * int'(cur_stride));
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // GLB return model and ready drivers, applied just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rst || glb_q.size() == 0 || cyc < glb_q[0].due) begin
      RdDatVld = 1'b0;
      RdDat    = '0;
    end else begin
      RdDatVld = 1'b1;
      RdDat    = glb_word(glb_q[0].addr);
    end
    RdAddrRdy = addr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    OutDatRdy = (out_mode == 0) ? 1'b1 : (out_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  // Monitor: everything seen here is what the next rising edge acts on
  always @(negedge clk) begin
    if (rst) begin
      glb_q.delete();
      hold_a = 0; hold_o = 0; prev_done = 0;
    end else begin
      if (hold_a) begin
        chk("addr_hold_vld", RdAddrVld, 1'b1);
        chk("addr_hold", RdAddr, hold_addr);
      end
      if (hold_o) begin
        chk("out_hold_vld", OutDatVld, 1'b1);
        chk("out_hold", OutDat, hold_dat);
      end
      if (prev_done) chk("done_width", Done, 1'b0);
      if (Done) begin
        chk("done_cycle", cyc, exp_done);
        chk("addr_count", k_a, cur_num);
        chk("out_count", k_o, cur_num);
`ifdef GLB_RD_AGENT_MON_EN
        chk("mon_addr_stall", MonDat[31:0], a_stall);
        chk("mon_out_stall", MonDat[63:32], o_stall);
`else
        chk("mon_zero", MonDat, 64'd0);
`endif
        done_cnt++;
      end
      prev_done = Done;
      if (CfgVld && CfgRdy) begin
        cur_base = CfgBaseAddr; cur_stride = CfgStride; cur_num = CfgNum;
        k_a = 0; k_o = 0; acc_cyc = cyc; a_stall = 0; o_stall = 0; vld_cycles = 0;
        addr_cyc.delete(); addr_log.delete();
        exp_done = (CfgNum == 0) ? cyc + 1 : -1;
      end
      if (RdAddrVld) vld_cycles++;
      if (RdAddrVld && RdAddrRdy) begin
        chk("rd_addr", RdAddr, exp_addr(k_a));
        addr_cyc.push_back(cyc);
        addr_log.push_back(RdAddr);
        glb_q.push_back('{addr: RdAddr, due: cyc + int'($urandom_range(lat_min, lat_max))});
        k_a++;
      end
      hold_a = RdAddrVld && !RdAddrRdy;
      hold_addr = RdAddr;
      if (hold_a) a_stall++;
      if (RdDatVld) chk("dat_rdy", RdDatRdy, 1'b1);
      if (RdDatVld && RdDatRdy && glb_q.size() > 0) void'(glb_q.pop_front());
      if (OutDatVld && OutDatRdy) begin
        chk("out_dat", OutDat, glb_word(exp_addr(k_o)));
        chk("out_last", OutLast, (k_o == int'(cur_num) - 1));
        k_o++;
        if (k_o == int'(cur_num)) exp_done = cyc + 1;
      end
      hold_o = OutDatVld && !OutDatRdy;
      hold_dat = OutDat;
      if (hold_o) o_stall++;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_cfgrdy"}, CfgRdy, 1'b1);
    chk({tag, "_busy"}, Busy, 1'b0);
    chk({tag, "_done"}, Done, 1'b0);
    chk({tag, "_addrvld"}, RdAddrVld, 1'b0);
    chk({tag, "_addr"}, RdAddr, 16'h0);
    chk({tag, "_datrdy"}, RdDatRdy, 1'b1);
    chk({tag, "_outvld"}, OutDatVld, 1'b0);
    chk({tag, "_outlast"}, OutLast, 1'b0);
    chk({tag, "_outdat"}, OutDat, 256'h0);
    chk({tag, "_mon"}, MonDat, 64'h0);
  endtask

  task automatic send_cmd(input logic [15:0] b, input logic [15:0] s, input logic [15:0] n);
    @(posedge clk); #1;
    CfgVld = 1'b1; CfgBaseAddr = b; CfgStride = s; CfgNum = n;
    @(posedge clk); #1;
    CfgVld = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start, n;
    start = done_cnt; n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", (done_cnt != start), 1'b1);
  endtask

  initial begin
    logic [15:0] wrap_exp[4];
    int n;
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    rst = 1'b1; CfgVld = 1'b0; CfgBaseAddr = '0; CfgStride = '0; CfgNum = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    @(posedge clk); #1 rst = 1'b0;

    // basic stride-1 read at full throughput
    send_cmd(16'h0010, 16'd1, 16'd4);
    wait_done(100);
    chk("t1_first_addr_cyc", addr_cyc[0], acc_cyc + 1);
    chk("t1_last_addr_cyc", addr_cyc[3], acc_cyc + 4);

    // empty command
    send_cmd(16'h1234, 16'd7, 16'd0);
    wait_done(20);
    chk("t2_no_addr_vld", vld_cycles, 0);
    @(negedge clk);
    chk("t2_cfgrdy_back", CfgRdy, 1'b1);

    // address wrap
    send_cmd(16'hFFFE, 16'd1, 16'd4);
    wait_done(100);
    for (int i = 0; i < 4; i++) chk("t3_wrap_addr", addr_log[i], wrap_exp[i]);

    // consumer stalled: credits cap issued addresses at FIFO depth
    out_mode = 2;
    send_cmd(16'h0100, 16'd1, 16'd16);
    repeat (20) @(posedge clk);
    chk("t4_held_addr_hs", k_a, 4);
    out_mode = 0;
    wait_done(200);

    // randomized handshakes and GLB latency
    addr_rand = 1; out_mode = 1; lat_min = 1; lat_max = 3;
    send_cmd(16'($urandom), 16'd3, 16'd37);
    wait_done(2000);
    addr_rand = 0; out_mode = 0;

    // reset mid-request with two words in flight
    lat_min = 3; lat_max = 3;
    send_cmd(16'h0040, 16'd1, 16'd8);
    n = 0;
    while (k_a < 2 && n < 50) begin @(posedge clk); n++; end
    chk("t6_two_outstanding", k_a, 2);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    @(posedge clk); #1 rst = 1'b0;
    lat_min = 1; lat_max = 2;
    send_cmd(16'h2000, 16'd2, 16'd5);
    wait_done(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
